// File: rtl/addsub_bist.sv
// Exhaustive BIST initiator/checker for an N-bit combinational adder-subtractor.
// Latency: each vector held HOLD cycles, compared on the last; sweep = 2^(2N+1)*HOLD cycles.
// Backpressure: none; start is ignored while a sweep is running.
module addsub_bist #(
    parameter int N     = 4,
    parameter int HOLD  = 1,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     dut_a,
    output logic [N-1:0]     dut_b,
    output logic             dut_cin,
    input  logic [N-1:0]     dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [N-1:0]     first_a,
    output logic [N-1:0]     first_b,
    output logic             first_cin
);

    localparam int VW = 2 * N + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [VW-1:0]    V_LAST  = {VW{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [VW-1:0]     v;
    logic [HW-1:0]     hold_cnt;
    logic              cmp;
    logic              mismatch;
    logic [N-1:0]      op_b;
    logic [N:0]        golden;
    logic [ERR_W-1:0]  err_inc;

    // The driven operands are the vector counter itself, so they are registered.
    assign dut_a   = v[N-1:0];
    assign dut_b   = v[2*N-1:N];
    assign dut_cin = v[2*N];

    assign op_b     = dut_cin ? ~dut_b : dut_b;
    assign golden   = {1'b0, dut_a} + {1'b0, op_b} + {{N{1'b0}}, dut_cin};
    assign cmp      = (state == RUN) && (hold_cnt == HW'(HOLD - 1));
    assign mismatch = cmp && ({dut_cout, dut_sum} != golden);
    assign err_inc  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (cmp && v == V_LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v          <= '0;
            hold_cnt   <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_a    <= '0;
            first_b    <= '0;
            first_cin  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (state != RUN && start) begin
            v          <= '0;
            hold_cnt   <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_a    <= '0;
            first_b    <= '0;
            first_cin  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (state == RUN) begin
            if (cmp) begin
                hold_cnt <= '0;
                if (mismatch) begin
                    err_cnt <= err_inc;
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        first_a    <= dut_a;
                        first_b    <= dut_b;
                        first_cin  <= dut_cin;
                    end
                end
                // Last vector: operands stay put and the verdict includes this compare.
                if (v == V_LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= !mismatch && (err_cnt == '0);
                end else begin
                    v <= v + VW'(1);
                end
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_bist.sv
// Bench for addsub_bist: three instances (baseline, 4-bit error counter, HOLD=3) each beside a faultable adder-subtractor model.
module tb_addsub_bist;

    typedef struct {
        int   err;
        logic fv;
        int   fa;
        int   fb;
        int   fc;
        logic ps;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_x = 1'b0;
    int   sel = 0;
    int   fault_m = 0;
    int   fault_s = 0;

    always #5 clk = ~clk;

    // Instance signals: _m baseline, _s saturating counter, _h HOLD=3
    logic        start_m, start_s, start_h;
    logic [3:0]  a_m, b_m, sum_m, fa_m, fb_m;
    logic [3:0]  a_s, b_s, sum_s, fa_s, fb_s;
    logic [3:0]  a_h, b_h, sum_h, fa_h, fb_h;
    logic        cin_m, cout_m, busy_m, done_m, pass_m, fv_m, fc_m;
    logic        cin_s, cout_s, busy_s, done_s, pass_s, fv_s, fc_s;
    logic        cin_h, cout_h, busy_h, done_h, pass_h, fv_h, fc_h;
    logic [15:0] err_m, err_h;
    logic [3:0]  err_s;

    function automatic logic [4:0] adder(input logic [3:0] a, input logic [3:0] b,
                                         input logic c, input int f);
        logic [4:0] r;
        if (c) r = {1'b0, a} + {1'b0, ~b} + 5'd1;
        else   r = {1'b0, a} + {1'b0, b};
        if (f == 1) r[4] = 1'b0;
        if (f == 2) r[0] = ~r[0];
        return r;
    endfunction

    assign {cout_m, sum_m} = adder(a_m, b_m, cin_m, fault_m);
    assign {cout_s, sum_s} = adder(a_s, b_s, cin_s, fault_s);
    assign {cout_h, sum_h} = adder(a_h, b_h, cin_h, 0);

    assign start_m = start_x && (sel == 0);
    assign start_s = start_x && (sel == 1);
    assign start_h = start_x && (sel == 2);

    addsub_bist #(.N(4), .HOLD(1), .ERR_W(16)) u_m (
        .clk(clk), .rst_n(rst_n), .start(start_m),
        .dut_a(a_m), .dut_b(b_m), .dut_cin(cin_m), .dut_sum(sum_m), .dut_cout(cout_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m),
        .fail_valid(fv_m), .first_a(fa_m), .first_b(fb_m), .first_cin(fc_m));

    addsub_bist #(.N(4), .HOLD(1), .ERR_W(4)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .dut_a(a_s), .dut_b(b_s), .dut_cin(cin_s), .dut_sum(sum_s), .dut_cout(cout_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
        .fail_valid(fv_s), .first_a(fa_s), .first_b(fb_s), .first_cin(fc_s));

    addsub_bist #(.N(4), .HOLD(3), .ERR_W(16)) u_h (
        .clk(clk), .rst_n(rst_n), .start(start_h),
        .dut_a(a_h), .dut_b(b_h), .dut_cin(cin_h), .dut_sum(sum_h), .dut_cout(cout_h),
        .busy(busy_h), .done(done_h), .pass(pass_h), .err_cnt(err_h),
        .fail_valid(fv_h), .first_a(fa_h), .first_b(fb_h), .first_cin(fc_h));

    // Observation mux onto the selected instance
    logic        o_busy, o_done, o_pass, o_fv, o_cin, o_fc;
    logic [3:0]  o_a, o_b, o_fa, o_fb;
    logic [31:0] o_err;

    always_comb begin
        o_busy = busy_m; o_done = done_m; o_pass = pass_m; o_fv = fv_m;
        o_a = a_m; o_b = b_m; o_cin = cin_m; o_fa = fa_m; o_fb = fb_m; o_fc = fc_m;
        o_err = 32'(err_m);
        if (sel == 1) begin
            o_busy = busy_s; o_done = done_s; o_pass = pass_s; o_fv = fv_s;
            o_a = a_s; o_b = b_s; o_cin = cin_s; o_fa = fa_s; o_fb = fb_s; o_fc = fc_s;
            o_err = 32'(err_s);
        end else if (sel == 2) begin
            o_busy = busy_h; o_done = done_h; o_pass = pass_h; o_fv = fv_h;
            o_a = a_h; o_b = b_h; o_cin = cin_h; o_fa = fa_h; o_fb = fb_h; o_fc = fc_h;
            o_err = 32'(err_h);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_pass"}, 32'(o_pass), 0);
        chk({tag, "_err"},  o_err, 0);
        chk({tag, "_fv"},   32'(o_fv), 0);
        chk({tag, "_vec"},  32'({o_cin, o_b, o_a}), 0);
        chk({tag, "_first"}, 32'({o_fc, o_fb, o_fa}), 0);
    endtask

    // Launch a sweep on instance sel, follow it, then score the result against the queued expectation.
    task automatic run_sweep(input string tag, input int hold, input int restart_at, input exp_t e);
        int   cnt;
        int   vec_bad;
        int   err_at_start;
        int   idx;
        logic [8:0] vv;
        exp_t got;
        sb.push_back(e);
        @(negedge clk) start_x = 1'b1;
        @(negedge clk) start_x = 1'b0;
        cnt = 0;
        vec_bad = 0;
        err_at_start = int'(o_err);
        while (o_busy === 1'b1 && cnt < 4000) begin
            idx = cnt / hold;
            vv  = idx[8:0];
            if ({o_cin, o_b, o_a} !== vv) vec_bad++;
            cnt++;
            if (cnt == restart_at)     start_x = 1'b1;
            if (cnt == restart_at + 1) start_x = 1'b0;
            @(negedge clk);
        end
        start_x = 1'b0;
        chk({tag, "_err_cleared"}, 32'(err_at_start), 0);
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(512 * hold));
        chk({tag, "_vec_seq_bad"}, 32'(vec_bad), 0);
        chk({tag, "_done"}, 32'(o_done), 1);
        chk({tag, "_last_vec"}, 32'({o_cin, o_b, o_a}), 32'h1ff);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            got = sb.pop_front();
            chk({tag, "_err_cnt"}, o_err, 32'(got.err));
            chk({tag, "_fail_valid"}, 32'(o_fv), 32'(got.fv));
            chk({tag, "_first_a"}, 32'(o_fa), 32'(got.fa));
            chk({tag, "_first_b"}, 32'(o_fb), 32'(got.fb));
            chk({tag, "_first_cin"}, 32'(o_fc), 32'(got.fc));
            chk({tag, "_pass"}, 32'(o_pass), 32'(got.ps));
        end
        // DONE must hold its results with no further start
        repeat (5) @(negedge clk);
        chk({tag, "_done_hold"}, 32'({o_done, o_pass}), 32'({1'b1, got.ps}));
    endtask

    initial begin
        exp_t e_ok, e_cout, e_sat;
        e_ok   = '{err: 0,   fv: 1'b0, fa: 0,  fb: 0, fc: 0, ps: 1'b1};
        e_cout = '{err: 256, fv: 1'b1, fa: 15, fb: 1, fc: 0, ps: 1'b0};
        e_sat  = '{err: 15,  fv: 1'b1, fa: 0,  fb: 0, fc: 0, ps: 1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_zero("idle");

        sel = 0; fault_m = 0;
        run_sweep("t1", 1, -10, e_ok);

        fault_m = 1;
        run_sweep("t2", 1, -10, e_cout);

        fault_m = 0;
        run_sweep("t5", 1, 100, e_ok);

        // Mid-sweep asynchronous reset
        @(negedge clk) start_x = 1'b1;
        @(negedge clk) start_x = 1'b0;
        repeat (200) @(negedge clk);
        chk("t6_busy_before_rst", 32'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("t6_rst");
        @(negedge clk);
        chk_idle_zero("t6_held");
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep("t6_rerun", 1, -10, e_ok);

        sel = 1; fault_s = 2;
        run_sweep("t3", 1, -10, e_sat);

        sel = 2;
        run_sweep("t4", 3, -10, e_ok);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
